// File: rtl/alu_pipe.sv
// alu_pipe: clocked, parametrised ALU with a valid/ready operand handshake.
// Single-cycle ops finish in EXEC; MUL (shift-add) and DIV (restoring) take
// WIDTH iterations in ITER plus one finalize cycle. Results are held in DONE
// until the consumer takes them. Only one operation is in flight at a time.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             neg,
  output logic             div0
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
                         OP_LSL  = 4'h4, OP_LSR  = 4'h5, OP_ROL  = 4'h6, OP_ROR  = 4'h7,
                         OP_AND  = 4'h8, OP_OR   = 4'h9, OP_XOR  = 4'hA, OP_NOR  = 4'hB,
                         OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_GT   = 4'hE, OP_EQ   = 4'hF;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  // registered result bundle, presented on the output ports
  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             c;
    logic             z;
    logic             v;
    logic             n;
    logic             d;
  } res_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] acc_hi, acc_lo;   // MUL: product hi/lo; DIV: remainder/quotient
  logic [CW-1:0]    cnt;
  res_t             res_q, sc_res, it_res;

  logic             is_iter_op;
  logic [WIDTH:0]   add_sum, sub_dif;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh, div_dif;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;

  assign is_iter_op = (alu_sel == OP_MUL) || (alu_sel == OP_DIV);

  assign add_sum = {1'b0, op_a} + {1'b0, op_b};
  assign sub_dif = {1'b0, op_a} - {1'b0, op_b};

  // one shift-add step: add multiplicand when the current multiplier LSB is set
  assign mul_sum = {1'b0, acc_hi} + ({1'b0, op_a} & {(WIDTH+1){acc_lo[0]}});

  // one restoring-divide step: bring in the next dividend bit, subtract if it fits
  assign div_sh  = {acc_hi, acc_lo[M]};
  assign div_ok  = (div_sh >= {1'b0, op_b});
  assign div_dif = div_sh - {1'b0, op_b};
  assign div_rem = div_ok ? div_dif[M:0] : div_sh[M:0];

  // single-cycle op results and flags from the latched operands
  always_comb begin
    sc_res = '0;
    case (op_sel)
      OP_ADD: begin
        sc_res.lo = add_sum[M:0];
        sc_res.c  = add_sum[WIDTH];
        sc_res.v  = (op_a[M] == op_b[M]) && (add_sum[M] != op_a[M]);
      end
      OP_SUB: begin
        sc_res.lo = sub_dif[M:0];
        sc_res.c  = ~sub_dif[WIDTH];
        sc_res.v  = (op_a[M] != op_b[M]) && (sub_dif[M] != op_a[M]);
      end
      OP_LSL: begin
        sc_res.lo = {op_a[M-1:0], 1'b0};
        sc_res.c  = op_a[M];
      end
      OP_LSR: begin
        sc_res.lo = {1'b0, op_a[M:1]};
        sc_res.c  = op_a[0];
      end
      OP_ROL:  sc_res.lo = {op_a[M-1:0], op_a[M]};
      OP_ROR:  sc_res.lo = {op_a[0], op_a[M:1]};
      OP_AND:  sc_res.lo = op_a & op_b;
      OP_OR:   sc_res.lo = op_a | op_b;
      OP_XOR:  sc_res.lo = op_a ^ op_b;
      OP_NOR:  sc_res.lo = ~(op_a | op_b);
      OP_NAND: sc_res.lo = ~(op_a & op_b);
      OP_XNOR: sc_res.lo = ~(op_a ^ op_b);
      OP_GT:   sc_res.lo = WIDTH'(op_a > op_b);
      OP_EQ:   sc_res.lo = WIDTH'(op_a == op_b);
      default: sc_res.lo = '0;   // MUL/DIV never finish through EXEC
    endcase
    sc_res.z = (sc_res.lo == '0);
    sc_res.n = sc_res.lo[M];
  end

  // MUL/DIV results and flags once all iterations are done
  always_comb begin
    it_res    = '0;
    it_res.lo = acc_lo;
    it_res.hi = acc_hi;
    it_res.n  = acc_lo[M];
    if (op_sel == OP_MUL) begin
      it_res.v = (acc_hi != '0);
      it_res.z = (acc_hi == '0) && (acc_lo == '0);
    end else begin
      // b==0 falls out of the restoring loop as quotient all-ones, remainder a
      it_res.d = (op_b == '0);
      it_res.v = (op_b == '0);
      it_res.z = (acc_lo == '0);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: state_nxt = in_valid ? (is_iter_op ? ITER : EXEC) : IDLE;
      EXEC: state_nxt = DONE;
      ITER: state_nxt = (cnt == LAST) ? DONE : ITER;
      DONE: state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch, iteration datapath and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a   <= a;
          op_b   <= b;
          op_sel <= alu_sel;
          acc_hi <= '0;
          acc_lo <= (alu_sel == OP_MUL) ? b : a;
          cnt    <= '0;
        end
        EXEC: res_q <= sc_res;
        ITER: begin
          if (cnt != LAST) begin
            if (op_sel == OP_MUL) begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[M:1]};
            end else begin
              acc_hi <= div_rem;
              acc_lo <= {acc_lo[M-1:0], div_ok};
            end
            cnt <= cnt + CW'(1);
          end else begin
            res_q <= it_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q.lo;
  assign result_hi = res_q.hi;
  assign carry     = res_q.c;
  assign zero      = res_q.z;
  assign ovf       = res_q.v;
  assign neg       = res_q.n;
  assign div0      = res_q.d;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: WIDTH=8 and WIDTH=16 instances share the
// clock, reset and operand bus; a plain-arithmetic model supplies expectations.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0, ordy = 1'b0, use16 = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic [3:0]  sel = '0;

  int n_chk = 0;
  int n_err = 0;

  logic       ir8, ov8, c8, z8, v8, n8, d8;
  logic [7:0] r8, h8;
  logic        ir16, ov16, c16, z16, v16, n16, d16;
  logic [15:0] r16, h16;

  logic        o_ir, o_ov, o_c, o_z, o_v, o_n, o_d;
  logic [15:0] o_r, o_hi;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & ~use16), .in_ready(ir8),
    .a(a_in[7:0]), .b(b_in[7:0]), .alu_sel(sel),
    .out_valid(ov8), .out_ready(ordy), .result(r8), .result_hi(h8),
    .carry(c8), .zero(z8), .ovf(v8), .neg(n8), .div0(d8));

  alu_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & use16), .in_ready(ir16),
    .a(a_in), .b(b_in), .alu_sel(sel),
    .out_valid(ov16), .out_ready(ordy), .result(r16), .result_hi(h16),
    .carry(c16), .zero(z16), .ovf(v16), .neg(n16), .div0(d16));

  // view of whichever instance is under test
  always_comb begin
    if (use16) begin
      o_ir = ir16; o_ov = ov16; o_r = r16; o_hi = h16;
      o_c = c16; o_z = z16; o_v = v16; o_n = n16; o_d = d16;
    end else begin
      o_ir = ir8; o_ov = ov8; o_r = {8'h00, r8}; o_hi = {8'h00, h8};
      o_c = c8; o_z = z8; o_v = v8; o_n = n8; o_d = d8;
    end
  end

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] hi;
    logic        c, z, v, n, d;
    int          lat;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: the op table written as ordinary integer arithmetic
  function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic [3:0] s);
    exp_t e;
    longint unsigned x, y, m, r, hi, p;
    logic sx, sy, sr;
    e  = '0;
    m  = (64'd1 << w) - 1;
    x  = 64'(av) & m;
    y  = 64'(bv) & m;
    r  = 0;
    hi = 0;
    e.lat = 1;
    sx = ((x >> (w - 1)) & 1) != 0;
    sy = ((y >> (w - 1)) & 1) != 0;
    case (s)
      4'h0: begin
        p = x + y; r = p & m; e.c = (p > m);
        sr = ((r >> (w - 1)) & 1) != 0;
        e.v = (sx == sy) && (sr != sx);
      end
      4'h1: begin
        r = (x - y) & m; e.c = (x >= y);
        sr = ((r >> (w - 1)) & 1) != 0;
        e.v = (sx != sy) && (sr != sx);
      end
      4'h2: begin
        p = x * y; r = p & m; hi = p >> w; e.v = (hi != 0); e.lat = w + 1;
      end
      4'h3: begin
        e.lat = w + 1;
        if (y == 0) begin r = m; hi = x; e.d = 1'b1; e.v = 1'b1; end
        else begin r = x / y; hi = x % y; end
      end
      4'h4: begin r = (x << 1) & m; e.c = sx; end
      4'h5: begin r = x >> 1; e.c = (x & 1) != 0; end
      4'h6: r = ((x << 1) | (x >> (w - 1))) & m;
      4'h7: r = (x >> 1) | ((x & 1) << (w - 1));
      4'h8: r = x & y;
      4'h9: r = x | y;
      4'hA: r = x ^ y;
      4'hB: r = ~(x | y) & m;
      4'hC: r = ~(x & y) & m;
      4'hD: r = ~(x ^ y) & m;
      4'hE: r = (x > y) ? 1 : 0;
      default: r = (x == y) ? 1 : 0;
    endcase
    e.r = 16'(r);
    e.hi = 16'(hi);
    e.z = (s == 4'h2) ? (r == 0 && hi == 0) : (r == 0);
    e.n = ((r >> (w - 1)) & 1) != 0;
    return e;
  endfunction

  task automatic check_outs(input string t, input exp_t e);
    chk({t, " result"},    32'(o_r),  32'(e.r));
    chk({t, " result_hi"}, 32'(o_hi), 32'(e.hi));
    chk({t, " flags czvnd"}, 32'({o_c, o_z, o_v, o_n, o_d}),
                              32'({e.c, e.z, e.v, e.n, e.d}));
  endtask

  // issue one op, check latency and outputs, optionally stall the consumer
  task automatic do_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                       input logic [3:0] s, input int hold);
    exp_t  e;
    int    cyc;
    string t;
    e = model(w, av, bv, s);
    t = $sformatf("w%0d op%0h a=%0h b=%0h", w, s, av, bv);
    @(negedge clk);
    use16 = (w == 16); a_in = av; b_in = bv; sel = s; iv = 1'b1;
    cyc = 0;
    while (!o_ir && cyc < 50) begin @(negedge clk); cyc++; end
    chk({t, " in_ready"}, 32'(o_ir), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // scramble the inputs: the accepted operands must already be latched
    iv = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom); sel = 4'($urandom);
    cyc = 0;
    while (!o_ov && cyc < 40) begin @(negedge clk); cyc++; end
    chk({t, " latency"}, 32'(cyc), 32'(e.lat));
    check_outs(t, e);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin iv = 1'b1; sel = 4'h0; end
      @(negedge clk);
      chk({t, " hold out_valid/in_ready"}, 32'({o_ov, o_ir}), 32'b10);
      check_outs({t, " hold"}, e);
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy = 1'b0;
    chk({t, " release out_valid/in_ready"}, 32'({o_ov, o_ir}), 32'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    bit seen_ov;
    exp_t e0;
    repeat (3) @(negedge clk);
    e0 = '0;
    chk("reset w8 outs",  32'({ir8, ov8, r8, h8, c8, z8, v8, n8, d8}),  32'({1'b1, 1'b0, 16'h0, 5'h0}));
    chk("reset w16 ready/valid", 32'({ir16, ov16}), 32'b10);
    chk("reset w16 result",    32'({r16, h16}), 32'(e0.r));
    chk("reset w16 flags",     32'({c16, z16, v16, n16, d16}), 32'd0);
    rst_n = 1'b1;

    // arithmetic, multiply, divide corner cases
    do_op(8, 16'hF0, 16'h20, 4'h0, 0);
    do_op(8, 16'h80, 16'h01, 4'h1, 0);
    do_op(8, 16'h10, 16'h10, 4'h2, 0);
    do_op(8, 16'h0F, 16'h11, 4'h2, 0);
    do_op(8, 16'h64, 16'h07, 4'h3, 0);
    do_op(8, 16'h5A, 16'h00, 4'h3, 0);
    do_op(8, 16'h00, 16'h33, 4'h2, 0);
    do_op(8, 16'h7F, 16'h01, 4'h0, 0);
    // consumer stall with an ignored in_valid pulse
    do_op(8, 16'hA5, 16'h3C, 4'hA, 5);
    do_op(8, 16'h12, 16'h34, 4'hF, 0);

    // wide instance
    do_op(16, 16'h8001, 16'h0000, 4'h6, 0);
    do_op(16, 16'h8001, 16'h0000, 4'h4, 0);
    do_op(16, 16'hFFFF, 16'hFFFF, 4'h2, 0);
    do_op(16, 16'hBEEF, 16'h0000, 4'h3, 0);

    // reset in the middle of a DIV
    @(negedge clk);
    use16 = 1'b0; a_in = 16'h00C8; b_in = 16'h0003; sel = 4'h3; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-div reset outs", 32'({ir8, ov8, r8, h8, c8, z8, v8, n8, d8}), 32'({1'b1, 1'b0, 16'h0, 5'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    seen_ov = 1'b0;
    repeat (12) begin @(negedge clk); seen_ov |= ov8; end
    chk("no stale out_valid", 32'(seen_ov), 32'd0);
    do_op(8, 16'h01, 16'h01, 4'h0, 0);

    // randomized traffic across both widths
    for (int i = 0; i < 200; i++) begin
      int w;
      logic [15:0] ra, rb;
      w  = ($urandom_range(0, 1) == 1) ? 16 : 8;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (w == 8) begin ra[15:8] = '0; rb[15:8] = '0; end
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = ra;
        default: ;
      endcase
      do_op(w, ra, rb, 4'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
